// File: rtl/strand_control.sv
// strand_control: per-strand issue controller sequencing vector lanes, RAW bubbles and dcache-miss parking.
// Define STRAND_PERF_COUNTERS_EN to add 64-bit icache/raw/dcache stall counters.
module strand_control #(
    parameter int NUM_LANES     = 16,
    parameter int LANE_W        = $clog2(NUM_LANES),
    parameter int OFFSET_W      = 32,
    parameter int LOAD_LATENCY  = 2,
    parameter int ARITH_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         instruction_i,
    input  logic                instruction_valid_i,
    input  logic                grant_i,
    input  logic                flush_i,
    input  logic                suspend_strand_i,
    input  logic                resume_strand_i,
    input  logic [LANE_W-1:0]   rollback_reg_lane_i,
    input  logic [OFFSET_W-1:0] rollback_strided_offset_i,
    input  logic [31:0]         pc_i,
    output logic                issue_request_o,
    output logic                next_instruction_o,
    output logic [LANE_W-1:0]   reg_lane_select_o,
    output logic [OFFSET_W-1:0] strided_offset_o,
    output logic [31:0]         pc_o,
    output logic [31:0]         instruction_o,
    output logic [2:0]          strand_state_o
`ifdef STRAND_PERF_COUNTERS_EN
    ,
    output logic [63:0]         raw_wait_count_o,
    output logic [63:0]         dcache_wait_count_o,
    output logic [63:0]         icache_wait_count_o
`endif
);
    typedef enum logic [2:0] {
        NORMAL     = 3'd0,
        VLOAD      = 3'd1,
        VSTORE     = 3'd2,
        RAW_WAIT   = 3'd3,
        CACHE_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] MEM_SYNC       = 4'd5;
    localparam logic [3:0] MEM_STRIDED    = 4'd10;
    localparam logic [3:0] MEM_STRIDED_M  = 4'd11;
    localparam logic [3:0] MEM_STRIDED_IM = 4'd12;
    localparam logic [3:0] MEM_SCGATH     = 4'd13;
    localparam logic [3:0] MEM_SCGATH_M   = 4'd14;
    localparam logic [3:0] MEM_SCGATH_IM  = 4'd15;

    state_t              r_state;
    logic [3:0]          r_delay;
    logic [LANE_W-1:0]   r_lane;
    logic [OFFSET_W-1:0] r_offset;

    logic                w_fmt_a, w_fmt_b, w_fmt_c, w_load, w_multi, w_arith, w_sync;
    logic                w_issue, w_last, w_stalled, w_in_vec, w_step;
    logic [3:0]          w_op;
    logic [OFFSET_W-1:0] w_stride;

    assign w_fmt_a  = instruction_i[31:29] == 3'b110;
    assign w_fmt_b  = !instruction_i[31];
    assign w_fmt_c  = instruction_i[31:30] == 2'b10;
    assign w_op     = instruction_i[28:25];
    assign w_load   = instruction_i[29];
    assign w_multi  = w_fmt_c && (w_op inside {MEM_STRIDED, MEM_STRIDED_M, MEM_STRIDED_IM,
                                               MEM_SCGATH, MEM_SCGATH_M, MEM_SCGATH_IM});
    assign w_arith  = (w_fmt_a && instruction_i[28])
                   || (w_fmt_a && instruction_i[28:23] == 6'b000111)
                   || (w_fmt_b && instruction_i[30:26] == 5'b00111);
    assign w_sync   = w_fmt_c && !w_load && w_op == MEM_SYNC;
    assign w_stride = OFFSET_W'(instruction_i[24:15]);

    assign w_issue   = instruction_valid_i && grant_i;
    assign w_last    = r_lane == LANE_W'(NUM_LANES - 1) && r_state != CACHE_WAIT;
    assign w_stalled = r_state == RAW_WAIT || r_state == CACHE_WAIT;
    assign w_in_vec  = r_state == VLOAD || r_state == VSTORE || w_multi;
    assign w_step    = w_in_vec && !w_stalled && w_issue;

    assign issue_request_o    = instruction_valid_i && !flush_i && !w_stalled;
    assign next_instruction_o = grant_i && ((r_state == NORMAL && !w_multi) || (w_in_vec && w_last));
    assign reg_lane_select_o  = r_lane;
    assign strided_offset_o   = r_offset;
    assign strand_state_o     = r_state;
    assign pc_o               = pc_i;
    assign instruction_o      = instruction_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= NORMAL;
            r_delay <= '0;
        end else if (flush_i) begin
            r_state <= suspend_strand_i ? CACHE_WAIT : NORMAL;
            r_delay <= '0;
        end else begin
            case (r_state)
                NORMAL: if (w_issue) begin
                    if (w_multi && !w_last) begin
                        r_state <= w_load ? VLOAD : VSTORE;
                    end else if (w_fmt_c && (w_load || w_sync)) begin
                        r_state <= RAW_WAIT;
                        r_delay <= 4'(LOAD_LATENCY);
                    end else if (w_arith) begin
                        r_state <= RAW_WAIT;
                        r_delay <= 4'(ARITH_LATENCY);
                    end
                end
                VLOAD: if (w_last && w_issue) begin
                    r_state <= RAW_WAIT;
                    r_delay <= 4'(LOAD_LATENCY);
                end
                VSTORE: if (w_last && w_issue) r_state <= NORMAL;
                RAW_WAIT: begin
                    r_delay <= r_delay - 4'd1;
                    if (r_delay == 4'd1) r_state <= NORMAL;
                end
                CACHE_WAIT: if (resume_strand_i) r_state <= NORMAL;
                default: r_state <= NORMAL;
            endcase
        end
    end

    // Rollback outranks the flush that accompanies a suspend.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane   <= '0;
            r_offset <= '0;
        end else if (suspend_strand_i) begin
            r_lane   <= rollback_reg_lane_i;
            r_offset <= rollback_strided_offset_i;
        end else if (flush_i || (w_last && w_issue)) begin
            r_lane   <= '0;
            r_offset <= '0;
        end else if (w_step) begin
            r_lane   <= r_lane + LANE_W'(1);
            r_offset <= r_offset + w_stride;
        end
    end

`ifdef STRAND_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_wait_count_o    <= '0;
            dcache_wait_count_o <= '0;
            icache_wait_count_o <= '0;
        end else if (!instruction_valid_i) begin
            icache_wait_count_o <= icache_wait_count_o + 64'd1;
        end else if (r_state == RAW_WAIT) begin
            raw_wait_count_o    <= raw_wait_count_o + 64'd1;
        end else if (r_state == CACHE_WAIT) begin
            dcache_wait_count_o <= dcache_wait_count_o + 64'd1;
        end
    end
`endif
endmodule
